// File: rtl/rf_port_arbiter.sv
// Purpose: owns the register_block write port, both read ports and the shared warp select; arbitrates ALU/LSU write-back against operand fetch.
// Latency: acceptance in cycle N, register_block controls driven from flops in cycle N+1.
// Backpressure: none downstream; upstream held off with per-port ready (reads forced through after STARVE_LIM denials).
//
// Ports:
//   clk, rst                 sole clock (rising edge), synchronous active-high reset
//   rd_req_*                 operand-fetch request: valid/ready, warp, rs0, rs1, lane mask
//   wb0_* (ALU), wb1_* (LSU) write-back requests: valid/ready, warp, rd, lane mask, lane data
//   rf_write_en/waddr/wdata  register_block write port
//   rf_read_en_*/raddr_*     register_block read ports
//   rf_warp_selector         register_block warp select (shared by read and write)
//   rd_data_valid/warp       register_block rdata_* holds the requested operands this cycle
module rf_port_arbiter #(
   parameter int LANES      = 16,
   parameter int DATA_W     = 64,
   parameter int REG_AW     = 5,
   parameter int WARP_W     = 4,
   parameter int STARVE_LIM = 4
) (
   input  logic                      clk,
   input  logic                      rst,

   input  logic                      rd_req_valid,
   output logic                      rd_req_ready,
   input  logic [WARP_W-1:0]         rd_req_warp,
   input  logic [REG_AW-1:0]         rd_req_rs0,
   input  logic [REG_AW-1:0]         rd_req_rs1,
   input  logic [LANES-1:0]          rd_req_mask,

   input  logic                      wb0_valid,
   output logic                      wb0_ready,
   input  logic [WARP_W-1:0]         wb0_warp,
   input  logic [REG_AW-1:0]         wb0_rd,
   input  logic [LANES-1:0]          wb0_mask,
   input  logic [LANES*DATA_W-1:0]   wb0_data,

   input  logic                      wb1_valid,
   output logic                      wb1_ready,
   input  logic [WARP_W-1:0]         wb1_warp,
   input  logic [REG_AW-1:0]         wb1_rd,
   input  logic [LANES-1:0]          wb1_mask,
   input  logic [LANES*DATA_W-1:0]   wb1_data,

   output logic [LANES-1:0]          rf_write_en,
   output logic [REG_AW-1:0]         rf_waddr,
   output logic [LANES*DATA_W-1:0]   rf_wdata,
   output logic [LANES-1:0]          rf_read_en_0,
   output logic [LANES-1:0]          rf_read_en_1,
   output logic [REG_AW-1:0]         rf_raddr_0,
   output logic [REG_AW-1:0]         rf_raddr_1,
   output logic [WARP_W-1:0]         rf_warp_selector,
   output logic                      rd_data_valid,
   output logic [WARP_W-1:0]         rd_data_warp
);

   localparam int SW = $clog2(STARVE_LIM + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

   logic          rr_ptr;       // 0: wb0 wins a tie, 1: wb1 wins a tie
   logic [SW-1:0] starve_cnt;

   // Write-winner selection
   logic                    w_exists;
   logic                    w_sel;
   logic [WARP_W-1:0]       w_warp;
   logic [REG_AW-1:0]       w_rd;
   logic [LANES-1:0]        w_mask;
   logic [LANES*DATA_W-1:0] w_data;

   // Arbitration decisions
   logic same_warp;
   logic hazard;
   logic forced;
   logic w_grant;
   logic rd_ok;
   logic rd_grant;

   always_comb begin
      w_exists = wb0_valid | wb1_valid;
      w_sel    = (wb0_valid && wb1_valid) ? rr_ptr : wb1_valid;
      w_warp   = w_sel ? wb1_warp : wb0_warp;
      w_rd     = w_sel ? wb1_rd   : wb0_rd;
      w_mask   = w_sel ? wb1_mask : wb0_mask;
      w_data   = w_sel ? wb1_data : wb0_data;

      // The warp selector is shared, so a read can only ride along with a
      // write to the same warp; a write to one of its sources would be read
      // stale in the issue cycle, so that read waits one cycle.
      same_warp = (w_warp == rd_req_warp);
      hazard    = same_warp && ((w_rd == rd_req_rs0) || (w_rd == rd_req_rs1));
      forced    = rd_req_valid && (starve_cnt == STARVE_MAX);

      if (forced) begin
         rd_ok   = 1'b1;
         w_grant = w_exists && same_warp && !hazard;
      end else begin
         w_grant = w_exists;
         rd_ok   = !w_exists || (same_warp && !hazard);
      end

      if (rst) begin
         w_grant = 1'b0;
         rd_ok   = 1'b0;
      end

      rd_grant     = rd_req_valid && rd_ok;
      rd_req_ready = rd_ok;
      wb0_ready    = w_grant && !w_sel;
      wb1_ready    = w_grant &&  w_sel;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr           <= 1'b0;
         starve_cnt       <= '0;
         rf_write_en      <= '0;
         rf_waddr         <= '0;
         rf_wdata         <= '0;
         rf_read_en_0     <= '0;
         rf_read_en_1     <= '0;
         rf_raddr_0       <= '0;
         rf_raddr_1       <= '0;
         rf_warp_selector <= '0;
         rd_data_valid    <= 1'b0;
         rd_data_warp     <= '0;
      end else begin
         if (w_grant) begin
            rr_ptr <= ~w_sel;
         end

         if (rd_grant || !rd_req_valid) begin
            starve_cnt <= '0;
         end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
         end

         // Enables drop when ungranted; addresses and data keep their last value.
         rf_write_en <= w_grant ? w_mask : '0;
         if (w_grant) begin
            rf_waddr <= w_rd;
            rf_wdata <= w_data;
         end

         rf_read_en_0  <= rd_grant ? rd_req_mask : '0;
         rf_read_en_1  <= rd_grant ? rd_req_mask : '0;
         rd_data_valid <= rd_grant;
         if (rd_grant) begin
            rf_raddr_0   <= rd_req_rs0;
            rf_raddr_1   <= rd_req_rs1;
            rd_data_warp <= rd_req_warp;
         end

         // When both issue together their warps are equal by construction.
         if (w_grant) begin
            rf_warp_selector <= w_warp;
         end else if (rd_grant) begin
            rf_warp_selector <= rd_req_warp;
         end
      end
   end

endmodule
